// File: rtl/imem_arbiter.sv
// Two-port instruction memory arbiter with single-cycle registered response.
// Define IMEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module imem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int WORD_W    = 32,
  parameter int IMEM_SIZE = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              flush,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_addr_err,
  input  logic [WORD_W-1:0] mem_data
);

  localparam logic [ADDR_W-1:0] LP_SIZE = ADDR_W'(IMEM_SIZE);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_bad;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;

  logic r_inflight;
  logic r_port;
  logic r_bad;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic r_ptr;
  logic w_contest;

  // Flushed port 0 is not eligible, so that cycle is not a contest.
  assign w_contest = req0_valid & ~flush & req1_valid;
  assign w_gnt0    = rst_n & req0_valid & ~flush
                   & ~(w_contest & r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_contest) begin
      r_ptr <= ~r_ptr;
    end
  end
`else
  assign w_gnt0 = rst_n & req0_valid & ~flush;
`endif

  assign w_gnt1 = rst_n & req1_valid & ~w_gnt0;
  assign w_xfer = w_gnt0 | w_gnt1;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    w_addr = '0;
    unique case (1'b1)
      w_gnt1:  w_addr = req1_addr;
      w_gnt0:  w_addr = req0_addr;
      default: w_addr = '0;
    endcase
  end

  assign w_bad = (w_addr[1:0] != 2'b00)
               | (w_addr >= LP_SIZE);

  // Faulting transfers never reach memory.
  assign mem_req  = w_xfer & ~w_bad;
  assign mem_addr = mem_req ? w_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_port     <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      r_inflight <= w_xfer;
      r_port     <= w_gnt1;
      r_bad      <= w_xfer & w_bad;
    end
  end

  assign rsp0_valid = rst_n & r_inflight
                    & ~r_port & ~flush;
  assign rsp1_valid = rst_n & r_inflight & r_port;

  assign w_any    = rsp0_valid | rsp1_valid;
  assign rsp_err  = w_any & (r_bad | mem_addr_err);
  assign rsp_data = (w_any & ~rsp_err) ? mem_data : '0;

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of every address port.
REQ-002 Parameter WORD_W, default 32, width of every data port.
REQ-003 Parameter IMEM_SIZE, default 16384, instruction memory size in bytes; used only for the out-of-range check in REQ-019.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req0_valid / req0_ready / req0_addr  input / output / input  1 / 1 / ADDR_W  port 0 (fetch) request handshake.
REQ-007 req1_valid / req1_ready / req1_addr  input / output / input  1 / 1 / ADDR_W  port 1 (debug/loader) request handshake.
REQ-008 flush  input  1  squash port-0 traffic (branch redirect).
REQ-009 rsp0_valid / rsp1_valid  output  1 each  per-port response strobe.
REQ-010 rsp_data / rsp_err  output  WORD_W / 1  shared response payload and error flag.
REQ-011 mem_req / mem_addr  output  1 / ADDR_W  memory read request, combinational from grant.
REQ-012 mem_addr_err / mem_data  input  1 / WORD_W  memory response, registered by memory, valid one cycle after mem_req.

Function
REQ-013 A request SHALL transfer on a cycle where reqN_valid and reqN_ready are both 1; ready is combinational from valid, grant state and flush.
REQ-014 At most one port SHALL be granted per cycle; a back-to-back grant every cycle SHALL be sustained (fully pipelined, no bubble).
REQ-015 An aligned, in-range transfer in cycle N SHALL drive mem_req=1 and mem_addr=reqN_addr in cycle N, and rspN_valid=1 in cycle N+1 with rsp_data=mem_data and rsp_err=mem_addr_err.
REQ-016 A one-bit in-flight register with a port-ID register SHALL route the cycle-N+1 response to exactly one rspN_valid.
REQ-017 A transfer with addr[1:0]!=0 SHALL be accepted, SHALL NOT raise mem_req, and SHALL produce rspN_valid in N+1 with rsp_err=1 and rsp_data=0.
REQ-018 When rsp_err=1, rsp_data SHALL be 0 regardless of mem_data.
REQ-019 A transfer with addr>=IMEM_SIZE SHALL be handled as in REQ-017; mem_addr_err SHALL still be ORed into rsp_err.
REQ-020 flush=1 in cycle N SHALL force req0_ready=0 in cycle N and suppress rsp0_valid in cycle N (the response for a port-0 transfer made in N-1); port 1 is unaffected.
REQ-021 No transfer (both valid=0 or blocked) SHALL drive mem_req=0, mem_addr=0, and produce no response in the next cycle.
REQ-022 rsp0_valid and rsp1_valid SHALL never both be 1; rsp_data and rsp_err SHALL be 0 when neither is 1.
REQ-023 Responses have no backpressure; requesters SHALL sample them in the cycle they are valid.

Reset
REQ-024 While rst_n=0: req0_ready=0, req1_ready=0, rsp0_valid=0, rsp1_valid=0, rsp_data=0, rsp_err=0, mem_req=0, and the in-flight register, port-ID register and round-robin pointer (pointing at port 0) are all cleared.
REQ-025 Reset asserted mid-transfer SHALL drop the pending response; no rspN_valid follows reset deassertion.

Configuration
REQ-026 Macro IMEM_ARB_ROUND_ROBIN_EN defined: when both ports are valid, grant SHALL alternate, with a 1-bit pointer toggling after each contested grant and port 0 first after reset.
REQ-027 Macro undefined: fixed priority; port 0 always wins a contest and port 1 is granted only when req0_valid=0 or flush=1.

Verification
REQ-028 req0 at 0x0000_0010 with memory word 0xDEAD_BEEF -> mem_req and mem_addr=0x10 in the same cycle; next cycle rsp0_valid=1, rsp_data=0xDEADBEEF, rsp_err=0.
REQ-029 Both ports valid for 4 cycles with addresses 0x0, 0x4 (port 0) and 0x100 (port 1): with the macro, grants are P0,P1,P0,P1; without it, P0 for all 4 cycles and req1_ready=0 throughout.
REQ-030 req1 at 0x0000_0006 -> mem_req=0; next cycle rsp1_valid=1, rsp_err=1, rsp_data=0.
REQ-031 req0 at 0x4000 with IMEM_SIZE=16384 -> mem_req=0; next cycle rsp0_valid=1, rsp_err=1.
REQ-032 Port-0 transfer in cycle N with flush=1 in N+1 -> rsp0_valid=0 in N+1 and req0_ready=0 in N+1; a port-1 transfer in N+1 still gets rsp1_valid in N+2.
REQ-033 rst_n driven low in the cycle after a port-1 transfer -> all outputs 0 immediately; no rsp1_valid after release.
